// File: rtl/cnn_conv_1x1_sched.sv
// Sequencer for the 1x1 convolution datapath: per output channel it streams weights
// from RAM into the conv core, opens one full input pixel pass, then drains the adder results.
module cnn_conv_1x1_sched #(
    parameter int DATA_WIDTH      = 16,
    parameter int IMAGE_WIDTH     = 306,
    parameter int IMAGE_HEIGHT    = 306,
    parameter int CHANNEL_NUM_IN  = 64,
    parameter int CHANNEL_NUM_OUT = 128,
    parameter int ADDR_WIDTH      = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stride2_in,
    output logic                  wt_rd_en,
    output logic [ADDR_WIDTH-1:0] wt_rd_addr,
    input  logic [DATA_WIDTH-1:0] wt_rd_data,
    output logic                  valid_weight_out,
    output logic [DATA_WIDTH-1:0] weight_out,
    output logic                  stride2,
    output logic                  pxl_en,
    input  logic                  pxl_valid_in,
    input  logic                  res_valid_in,
    output logic [7:0]            oc_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int PIXEL_BEATS = IMAGE_WIDTH * IMAGE_HEIGHT * CHANNEL_NUM_IN;
    localparam int CNT_W       = $clog2(PIXEL_BEATS + 1);
    localparam int RD_W        = $clog2(CHANNEL_NUM_IN + 1);

    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIXEL_BEATS - 1);
    localparam logic [CNT_W-1:0] OUT_S1   = CNT_W'(IMAGE_WIDTH * IMAGE_HEIGHT);
    localparam logic [CNT_W-1:0] OUT_S2   = CNT_W'((IMAGE_WIDTH / 2) * (IMAGE_HEIGHT / 2));
    localparam logic [RD_W-1:0]  RD_LAST  = RD_W'(CHANNEL_NUM_IN - 1);
    localparam logic [7:0]       OC_LAST  = 8'(CHANNEL_NUM_OUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    wt_rd_en_q, wt_rd_en_d;
    logic [ADDR_WIDTH-1:0]   wt_rd_addr_q, wt_rd_addr_d;
    logic [RD_W-1:0]         rd_cnt_q, rd_cnt_d;
    logic                    rd_en_dly_q, rd_en_dly_d;
    logic                    valid_weight_q, valid_weight_d;
    logic [DATA_WIDTH-1:0]   weight_q, weight_d;
    logic                    stride2_q, stride2_d;
    logic                    pxl_en_q, pxl_en_d;
    logic [CNT_W-1:0]        pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]        res_cnt_q, res_cnt_d;
    logic [7:0]              oc_idx_q, oc_idx_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [CNT_W-1:0]        out_beats;
    logic                    res_window;
    logic                    pix_ok;
    logic                    res_ok;
    logic                    res_over;

    assign out_beats  = stride2_q ? OUT_S2 : OUT_S1;
    assign res_window = (state_q == S_STREAM) || (state_q == S_DRAIN);
    assign pix_ok     = pxl_valid_in && pxl_en_q;
    assign res_over   = res_cnt_q >= out_beats;
    assign res_ok     = res_valid_in && res_window && !res_over;

    always_comb begin
        state_d        = state_q;
        wt_rd_en_d     = wt_rd_en_q;
        wt_rd_addr_d   = wt_rd_addr_q;
        rd_cnt_d       = rd_cnt_q;
        rd_en_dly_d    = wt_rd_en_q;
        valid_weight_d = rd_en_dly_q;
        weight_d       = rd_en_dly_q ? wt_rd_data : weight_q;
        stride2_d      = stride2_q;
        pxl_en_d       = pxl_en_q;
        pix_cnt_d      = pix_cnt_q;
        res_cnt_d      = res_cnt_q;
        oc_idx_d       = oc_idx_q;
        busy_d         = busy_q;
        done_d         = 1'b0;
        err_d          = err_q
                         | (pxl_valid_in && !pxl_en_q)
                         | (res_valid_in && !res_window)
                         | (res_valid_in && res_window && res_over);

        // Offending beats are dropped; legal pixel and result beats may coincide.
        if (pix_ok) begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
        end
        if (res_ok) begin
            res_cnt_d = res_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stride2_d    = stride2_in;
                    oc_idx_d     = 8'd0;
                    wt_rd_en_d   = 1'b1;
                    wt_rd_addr_d = '0;
                    rd_cnt_d     = '0;
                    pix_cnt_d    = '0;
                    res_cnt_d    = '0;
                    busy_d       = 1'b1;
                    state_d      = S_LOAD;
                end
            end

            S_LOAD: begin
                if (wt_rd_en_q) begin
                    rd_cnt_d = rd_cnt_q + RD_W'(1);
                    if (rd_cnt_q == RD_LAST) begin
                        wt_rd_en_d = 1'b0;
                    end else begin
                        wt_rd_addr_d = wt_rd_addr_q + ADDR_WIDTH'(1);
                    end
                end
                // The read burst is contiguous, so the last weight is the one with no read behind it.
                if (valid_weight_q && !rd_en_dly_q) begin
                    pxl_en_d = 1'b1;
                    state_d  = S_STREAM;
                end
            end

            S_STREAM: begin
                if (pix_ok && (pix_cnt_q == PIX_LAST)) begin
                    pxl_en_d = 1'b0;
                    state_d  = S_DRAIN;
                end
            end

            S_DRAIN: begin
                // A channel may already be complete on entry if results arrived during the stream.
                if (res_cnt_d == out_beats) begin
                    if (oc_idx_q == OC_LAST) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        oc_idx_d     = oc_idx_q + 8'd1;
                        wt_rd_en_d   = 1'b1;
                        wt_rd_addr_d = wt_rd_addr_q + ADDR_WIDTH'(1);
                        rd_cnt_d     = '0;
                        pix_cnt_d    = '0;
                        res_cnt_d    = '0;
                        state_d      = S_LOAD;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            wt_rd_en_q     <= 1'b0;
            wt_rd_addr_q   <= '0;
            rd_cnt_q       <= '0;
            rd_en_dly_q    <= 1'b0;
            valid_weight_q <= 1'b0;
            weight_q       <= '0;
            stride2_q      <= 1'b0;
            pxl_en_q       <= 1'b0;
            pix_cnt_q      <= '0;
            res_cnt_q      <= '0;
            oc_idx_q       <= 8'd0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            wt_rd_en_q     <= wt_rd_en_d;
            wt_rd_addr_q   <= wt_rd_addr_d;
            rd_cnt_q       <= rd_cnt_d;
            rd_en_dly_q    <= rd_en_dly_d;
            valid_weight_q <= valid_weight_d;
            weight_q       <= weight_d;
            stride2_q      <= stride2_d;
            pxl_en_q       <= pxl_en_d;
            pix_cnt_q      <= pix_cnt_d;
            res_cnt_q      <= res_cnt_d;
            oc_idx_q       <= oc_idx_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign wt_rd_en         = wt_rd_en_q;
    assign wt_rd_addr       = wt_rd_addr_q;
    assign valid_weight_out = valid_weight_q;
    assign weight_out       = weight_q;
    assign stride2          = stride2_q;
    assign pxl_en           = pxl_en_q;
    assign oc_idx           = oc_idx_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_cnn_conv_1x1_sched.sv
// Scoreboard bench for cnn_conv_1x1_sched with CIN=4, COUT=2, 4x4 image.
// Stimulus pushes expected addresses/weights/done records; a negedge monitor pops and compares.
module tb_cnn_conv_1x1_sched;

    localparam int CIN  = 4;
    localparam int COUT = 2;
    localparam int IW   = 4;
    localparam int IH   = 4;
    localparam int AW   = 13;
    localparam int DW   = 16;
    localparam int PIX  = IW * IH * CIN;
    localparam int OUT1 = IW * IH;
    localparam int OUT2 = (IW / 2) * (IH / 2);

    logic          clk;
    logic          reset;
    logic          start;
    logic          stride2_in;
    logic          wt_rd_en;
    logic [AW-1:0] wt_rd_addr;
    logic [DW-1:0] wt_rd_data;
    logic          valid_weight_out;
    logic [DW-1:0] weight_out;
    logic          stride2;
    logic          pxl_en;
    logic          pxl_valid_in;
    logic          res_valid_in;
    logic [7:0]    oc_idx;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_wt[$];
    logic [8:0]    exp_done[$];

    logic [43:0] out_vec;
    assign out_vec = {wt_rd_en, wt_rd_addr, valid_weight_out, weight_out, stride2,
                      pxl_en, oc_idx, busy, done, err};

    cnn_conv_1x1_sched #(
        .DATA_WIDTH      (DW),
        .IMAGE_WIDTH     (IW),
        .IMAGE_HEIGHT    (IH),
        .CHANNEL_NUM_IN  (CIN),
        .CHANNEL_NUM_OUT (COUT),
        .ADDR_WIDTH      (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .stride2_in       (stride2_in),
        .wt_rd_en         (wt_rd_en),
        .wt_rd_addr       (wt_rd_addr),
        .wt_rd_data       (wt_rd_data),
        .valid_weight_out (valid_weight_out),
        .weight_out       (weight_out),
        .stride2          (stride2),
        .pxl_en           (pxl_en),
        .pxl_valid_in     (pxl_valid_in),
        .res_valid_in     (res_valid_in),
        .oc_idx           (oc_idx),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return 16'hA5C3 ^ {a, 3'b101};
    endfunction

    // Synchronous weight RAM: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (wt_rd_en) wt_rd_data <= ram_word(wt_rd_addr);
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic failEmpty(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=event expected=none at %0t", name, $time);
    endtask

    // Monitor: every weight read, weight strobe and done pulse must match the queued expectation.
    always @(negedge clk) begin
        if (wt_rd_en) begin
            if (exp_addr.size() == 0) failEmpty("unexpected_wt_rd_en");
            else checkOutput("wt_rd_addr", 64'(wt_rd_addr), 64'(exp_addr.pop_front()));
        end
        if (valid_weight_out) begin
            if (exp_wt.size() == 0) failEmpty("unexpected_valid_weight");
            else checkOutput("weight_out", 64'(weight_out), 64'(exp_wt.pop_front()));
        end
        if (done) begin
            if (exp_done.size() == 0) failEmpty("unexpected_done");
            else checkOutput("done_oc_err", 64'({oc_idx, err}), 64'(exp_done.pop_front()));
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input bit s2, input int gap, input bit hold,
                                 input bit inj_load, input int n_stream0, input bit abort_ch1);
        int out_b;
        bit err_exp;
        int n_here;
        int n_cnt;
        int remaining;
        int w;
        out_b   = s2 ? OUT2 : OUT1;
        err_exp = inj_load || (n_stream0 > out_b);
        for (int c = 0; c < COUT; c++) begin
            for (int k = 0; k < CIN; k++) begin
                exp_addr.push_back(AW'(c * CIN + k));
                exp_wt.push_back(ram_word(AW'(c * CIN + k)));
            end
        end
        exp_done.push_back({8'(COUT - 1), err_exp});

        start      = 1'b1;
        stride2_in = s2;
        @(negedge clk);
        if (!hold) start = 1'b0;

        for (int ch = 0; ch < COUT; ch++) begin
            n_here = (ch == 0) ? n_stream0 : 0;
            checkOutput("load_rd_en", 64'(wt_rd_en), 64'd1);
            checkOutput("load_busy", 64'(busy), 64'd1);
            checkOutput("load_oc_idx", 64'(oc_idx), 64'(ch));
            checkOutput("load_stride2", 64'(stride2), 64'(s2));
            if (inj_load && ch == 0) pxl_valid_in = 1'b1;
            @(negedge clk);
            pxl_valid_in = 1'b0;
            if (inj_load && ch == 0) checkOutput("err_load_pixel", 64'(err), 64'd1);
            checkOutput("vw_early", 64'(valid_weight_out), 64'd0);
            @(negedge clk);
            checkOutput("vw_first", 64'(valid_weight_out), 64'd1);
            repeat (CIN - 1) @(negedge clk);
            checkOutput("pxl_en_pre", 64'(pxl_en), 64'd0);
            @(negedge clk);
            checkOutput("pxl_en_rise", 64'(pxl_en), 64'd1);

            for (int i = 0; i < PIX; i++) begin
                if (abort_ch1 && ch == 1 && i == 10) begin
                    reset = 1'b1;
                    @(negedge clk);
                    checkOutput("abort_outputs", 64'(out_vec), 64'd0);
                    reset = 1'b0;
                    exp_done.delete();
                    return;
                end
                if (i == PIX - 1) checkOutput("pxl_en_last", 64'(pxl_en), 64'd1);
                pxl_valid_in = 1'b1;
                res_valid_in = (i < n_here);
                @(negedge clk);
                pxl_valid_in = 1'b0;
                res_valid_in = 1'b0;
                if (n_here > out_b && i == out_b - 1) checkOutput("err_at_full", 64'(err), 64'd0);
                if (n_here > out_b && i == out_b) checkOutput("err_overflow", 64'(err), 64'd1);
                if (i == PIX - 1) checkOutput("pxl_en_fall", 64'(pxl_en), 64'd0);
                else repeat (gap - 1) @(negedge clk);
            end

            n_cnt     = (n_here < out_b) ? n_here : out_b;
            remaining = out_b - n_cnt;
            for (int j = 0; j < remaining; j++) begin
                res_valid_in = 1'b1;
                @(negedge clk);
                res_valid_in = 1'b0;
            end
            if (remaining == 0) begin
                w = 0;
                while (!(wt_rd_en || done) && w < 4) begin
                    @(negedge clk);
                    w++;
                end
                checkOutput("turnaround_bound", 64'(wt_rd_en || done), 64'd1);
            end
        end

        checkOutput("done_pulse", 64'(done), 64'd1);
        checkOutput("busy_at_done", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("done_clear", 64'(done), 64'd0);
        checkOutput("idle_busy", 64'(busy), 64'd0);
        checkOutput("idle_rd_en", 64'(wt_rd_en), 64'd0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_state", 64'(out_vec), 64'd0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        stride2_in   = 1'b0;
        pxl_valid_in = 1'b0;
        res_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_state", 64'(out_vec), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] basic job stride2=0");
        applyStimulus(1'b0, 1, 1'b0, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] stride2 job");
        applyStimulus(1'b1, 1, 1'b0, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] backpressure job");
        applyStimulus(1'b0, 3, 1'b0, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] pixel beat during LOAD");
        applyStimulus(1'b0, 1, 1'b0, 1'b1, 0, 1'b0);
        doReset();

        $display("[TB] result overflow in channel 0");
        applyStimulus(1'b0, 1, 1'b0, 1'b0, 17, 1'b0);
        doReset();

        $display("[TB] reset mid-stream of channel 1, then replay");
        applyStimulus(1'b0, 1, 1'b0, 1'b0, 0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1, 1'b0, 1'b0, 0, 1'b0);
        repeat (2) @(negedge clk);

        $display("[TB] start held across a job");
        applyStimulus(1'b0, 1, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus(1'b0, 1, 1'b0, 1'b0, 0, 1'b0);
        repeat (3) @(negedge clk);

        checkOutput("addr_queue_empty", 64'(exp_addr.size()), 64'd0);
        checkOutput("wt_queue_empty", 64'(exp_wt.size()), 64'd0);
        checkOutput("done_queue_empty", 64'(exp_done.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
